// File: rtl/instruction_fetch_pkg.sv
// Shared defaults for the instruction fetch front end.
package instruction_fetch_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;
endpackage

// File: rtl/instruction_prefetch_if.sv
// Fetch-side bundle: pipeline control, memory request/response, decode handoff.
interface instruction_prefetch_if #(
  parameter int ADDR_WIDTH = instruction_fetch_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = instruction_fetch_pkg::DEF_DATA_WIDTH
) ();
  logic                  pcWrite;
  logic                  redirectValid;
  logic [ADDR_WIDTH-1:0] redirectPc;
  logic                  memReqValid;
  logic                  memReqReady;
  logic [ADDR_WIDTH-1:0] memReqAddr;
  logic                  memRespValid;
  logic [DATA_WIDTH-1:0] memRespData;
  logic                  ifIdWrite;
  logic                  instrValid;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] programCounterOut;

  modport master (
    input  pcWrite,
    input  redirectValid,
    input  redirectPc,
    output memReqValid,
    input  memReqReady,
    output memReqAddr,
    input  memRespValid,
    input  memRespData,
    input  ifIdWrite,
    output instrValid,
    output instruction,
    output programCounterOut
  );

  modport slave (
    output pcWrite,
    output redirectValid,
    output redirectPc,
    input  memReqValid,
    output memReqReady,
    input  memReqAddr,
    output memRespValid,
    output memRespData,
    output ifIdWrite,
    input  instrValid,
    input  instruction,
    input  programCounterOut
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head reads as zero when empty.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case (1'b1)
        w_push && !w_pop: r_cnt <= r_cnt + 1'b1;
        w_pop && !w_push: r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/instruction_prefetch.sv
// Credit-based instruction prefetcher: issues sequential fetches,
// queues returns with their PCs, drops in-flight returns after redirect.
module instruction_prefetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC),
  parameter logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(DEF_PC_STEP)
) (
  input logic                    clk,
  input logic                    resetN,
  instruction_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop;

  logic [CW-1:0]         w_out_next;
  logic [CW-1:0]         w_q_count;
  logic [CW-1:0]         w_pq_count;
  logic                  w_credit;
  logic                  w_fire;
  logic                  w_resp;
  logic                  w_keep;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_q_empty;
  logic                  w_q_full;
  logic                  w_pq_empty;
  logic                  w_pq_full;
  logic [ADDR_WIDTH-1:0] w_resp_pc;
  logic [EW-1:0]         w_head;
  logic                  w_unused;

  // Queued plus in-flight (including doomed) entries must fit the queue.
  assign w_credit = ({1'b0, w_q_count} + {1'b0, r_outstanding})
                    < (CW+1)'(DEPTH);

  assign bus.memReqValid = resetN && bus.pcWrite
                           && !bus.redirectValid && w_credit;
  assign bus.memReqAddr  = r_pc;

  assign w_fire = bus.memReqValid && bus.memReqReady;
  assign w_resp = bus.memRespValid;
  assign w_keep = w_resp && (r_drop == '0);
  assign w_push = w_keep && !bus.redirectValid;
  assign w_pop  = bus.instrValid && bus.ifIdWrite
                  && !bus.redirectValid;

  always_comb begin
    w_out_next = r_outstanding;
    unique case (1'b1)
      w_fire && !w_resp: w_out_next = r_outstanding + 1'b1;
      w_resp && !w_fire: w_out_next = r_outstanding - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (bus.redirectValid) begin
        r_pc   <= bus.redirectPc;
        r_drop <= w_out_next;
      end else begin
        if (w_fire)
          r_pc <= r_pc + PC_STEP;
        if (w_resp && (r_drop != '0))
          r_drop <= r_drop - 1'b1;
      end
    end
  end

  // PCs of live requests, in issue order, matched to returns.
  fetch_queue #(
    .W     (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk     (clk),
    .resetN  (resetN),
    .i_push  (w_fire),
    .i_pop   (w_keep),
    .i_flush (bus.redirectValid),
    .i_data  (r_pc),
    .o_data  (w_resp_pc),
    .o_full  (w_pq_full),
    .o_empty (w_pq_empty),
    .o_count (w_pq_count)
  );

  fetch_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .resetN  (resetN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirectValid),
    .i_data  ({w_resp_pc, bus.memRespData}),
    .o_data  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  assign bus.instrValid        = !w_q_empty;
  assign bus.instruction       = w_head[DATA_WIDTH-1:0];
  assign bus.programCounterOut = w_head[EW-1:DATA_WIDTH];

  assign w_unused = &{1'b0, w_q_full, w_pq_full, w_pq_empty, w_pq_count};
endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed + randomized bench for instruction_prefetch with an
// in-order memory model and an expected-instruction-stream reference.
module tb_instruction_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  instruction_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  instruction_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  instruction_prefetch #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (DEPTH),
    .RESET_PC (32'h0000_0000), .PC_STEP (32'd4)
  ) dut (.clk(clk), .resetN(resetN), .bus(bus));

  instruction_prefetch #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (DEPTH),
    .RESET_PC (32'hFFFF_FFFC), .PC_STEP (32'd4)
  ) dut2 (.clk(clk), .resetN(resetN), .bus(bus2));

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready_at;
  } req_t;

  req_t        pend[$];
  logic [31:0] expq[$];
  int          ready_n, epoch, cyc;
  logic [31:0] fetch_pc;
  int          total, bad;

  bit          pw, rv, rdy, idw;
  logic [31:0] rpc;
  int          lat_min, lat_max, resp_pct;

  int          fires, cyc_since, first_valid_cyc;
  bit          saw_first;
  logic [31:0] first_pc, first_instr;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    expq.delete();
    ready_n  = 0;
    epoch    = 0;
    fetch_pc = 32'h0;
  endtask

  // One clock: drive, check before the edge, then advance the model.
  task automatic cycle();
    bit resp, doomed, ev, ef, pop;
    int nd, lat;
    bus.pcWrite       = pw;
    bus.redirectValid = rv;
    bus.redirectPc    = rpc;
    bus.memReqReady   = rdy;
    bus.ifIdWrite     = idw;
    resp = 1'b0;
    doomed = 1'b0;
    if (pend.size() > 0 && cyc >= pend[0].ready_at
        && int'($urandom_range(99)) < resp_pct)
      resp = 1'b1;
    if (resp) doomed = (pend[0].epoch != epoch);
    bus.memRespValid = resp;
    bus.memRespData  = resp ? memval(pend[0].addr) : $urandom;
    nd = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) nd++;
    ev  = pw && !rv && (expq.size() + nd < DEPTH);
    ef  = ev && rdy;
    pop = (ready_n > 0) && idw && !rv;
    #3;
    chk("memReqValid", 32'(bus.memReqValid), 32'(ev));
    chk("memReqAddr", bus.memReqAddr, fetch_pc);
    if (ready_n > 0) begin
      chk("instrValid", 32'(bus.instrValid), 32'd1);
      chk("pcOut", bus.programCounterOut, expq[0]);
      chk("instruction", bus.instruction, memval(expq[0]));
    end else begin
      chk("instrValid", 32'(bus.instrValid), 32'd0);
    end
    cyc_since++;
    if (bus.instrValid && !saw_first) begin
      saw_first       = 1'b1;
      first_valid_cyc = cyc_since;
      first_pc        = bus.programCounterOut;
      first_instr     = bus.instruction;
    end
    if (bus.memReqValid && rdy) fires++;
    @(posedge clk);
    #1;
    cyc++;
    if (resp) begin
      void'(pend.pop_front());
      if (!doomed && !rv) ready_n++;
    end
    if (rv) begin
      expq.delete();
      ready_n  = 0;
      epoch++;
      fetch_pc = rpc;
    end else begin
      if (pop) begin
        void'(expq.pop_front());
        ready_n--;
      end
      if (ef) begin
        lat = int'($urandom_range(lat_max, lat_min));
        expq.push_back(fetch_pc);
        pend.push_back('{fetch_pc, epoch, cyc + lat - 1});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic rand_knobs();
    pw  = ($urandom_range(99) < 80);
    rdy = ($urandom_range(99) < 70);
    idw = ($urandom_range(99) < 70);
    rv  = ($urandom_range(99) < 4);
    rpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8
                                   : ($urandom & 32'hFFFF_FFFC);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    fires = 0; cyc_since = 0; first_valid_cyc = 0; saw_first = 1'b0;
    first_pc = '0; first_instr = '0;
    pw = 1'b1; rv = 1'b0; rpc = '0; rdy = 1'b1; idw = 1'b1;
    lat_min = 1; lat_max = 1; resp_pct = 100;
    bus.pcWrite = 1'b1; bus.redirectValid = 1'b0; bus.redirectPc = '0;
    bus.memReqReady = 1'b1; bus.memRespValid = 1'b0;
    bus.memRespData = '0; bus.ifIdWrite = 1'b1;
    bus2.pcWrite = 1'b1; bus2.redirectValid = 1'b0; bus2.redirectPc = '0;
    bus2.memReqReady = 1'b1; bus2.memRespValid = 1'b0;
    bus2.memRespData = '0; bus2.ifIdWrite = 1'b0;
    model_reset();

    // Reset state, with fetch enabled throughout.
    #12;
    chk("rst_reqValid", 32'(bus.memReqValid), 32'd0);
    chk("rst_instrValid", 32'(bus.instrValid), 32'd0);
    chk("rst_instruction", bus.instruction, 32'd0);
    chk("rst_pcOut", bus.programCounterOut, 32'd0);
    chk("rst_addr", bus.memReqAddr, 32'd0);
    chk("rst2_addr", bus2.memReqAddr, 32'hFFFF_FFFC);
    chk("rst2_reqValid", 32'(bus2.memReqValid), 32'd0);

    @(negedge clk);
    resetN = 1'b1;
    cyc_since = 0; saw_first = 1'b0;
    #1;
    chk("wrap_first_addr", bus2.memReqAddr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_second_addr", bus2.memReqAddr, 32'h0000_0000);
    cycle();
    chk("wrap_third_addr", bus2.memReqAddr, 32'h0000_0004);
    repeat (8) cycle();
    chk("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
    chk("first_pc", first_pc, 32'h0);
    chk("first_instr", first_instr, memval(32'h0));

    // Decode stalled: credits cap issue at DEPTH.
    rv = 1'b1; rpc = 32'h40; cycle(); rv = 1'b0;
    idw = 1'b0; fires = 0;
    repeat (12) cycle();
    chk("stall_fires", 32'(fires), 32'(DEPTH));
    chk("stall_reqValid", 32'(bus.memReqValid), 32'd0);
    idw = 1'b1;
    repeat (8) cycle();

    // Memory back-pressure holds the request address.
    rdy = 1'b0; rv = 1'b1; rpc = 32'h10; cycle(); rv = 1'b0;
    repeat (3) begin
      cycle();
      chk("hold_addr", bus.memReqAddr, 32'h10);
    end
    chk("hold_valid", 32'(bus.memReqValid), 32'd1);
    rdy = 1'b1; cycle();
    chk("after_hold_addr", bus.memReqAddr, 32'h14);

    // Redirect with two requests in flight.
    pw = 1'b0; rv = 1'b1; rpc = 32'h200; cycle(); rv = 1'b0;
    repeat (6) cycle();
    lat_min = 3; lat_max = 3;
    pw = 1'b1; repeat (2) cycle();
    pw = 1'b0; rv = 1'b1; rpc = 32'h100; cycle();
    rv = 1'b0; pw = 1'b1; saw_first = 1'b0;
    repeat (10) cycle();
    chk("redir_first_pc", first_pc, 32'h100);
    chk("redir_first_instr", first_instr, memval(32'h100));

    // Redirect while fetch is frozen.
    pw = 1'b0; rv = 1'b1; rpc = 32'h300; cycle(); rv = 1'b0;
    chk("pw0_redir_addr", bus.memReqAddr, 32'h300);
    chk("pw0_flush", 32'(bus.instrValid), 32'd0);
    pw = 1'b1;

    // Randomized traffic.
    lat_min = 1; lat_max = 4; resp_pct = 70;
    repeat (600) begin
      rand_knobs();
      cycle();
    end

    // Fill the queue, then reset mid-stream.
    pw = 1'b1; rv = 1'b0; rdy = 1'b1; idw = 1'b0;
    lat_min = 1; lat_max = 2; resp_pct = 100;
    repeat (12) cycle();
    chk("pre_rst_valid", 32'(bus.instrValid), 32'd1);
    resetN = 1'b0;
    #1;
    chk("mid_rst_reqValid", 32'(bus.memReqValid), 32'd0);
    chk("mid_rst_instrValid", 32'(bus.instrValid), 32'd0);
    chk("mid_rst_instruction", bus.instruction, 32'd0);
    chk("mid_rst_pcOut", bus.programCounterOut, 32'd0);
    chk("mid_rst_addr", bus.memReqAddr, 32'd0);
    model_reset();
    bus.memRespValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    lat_min = 1; lat_max = 4; resp_pct = 70;
    repeat (200) begin
      rand_knobs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
